serial_compare_arbiter: RTL

Shares one MSB-first serial magnitude comparator among `N_REQ` requesters. Each requester offers a pair of parallel `WIDTH`-bit operands through a valid/ready handshake. A round-robin arbiter grants one request at a time. The block then shifts the operand bits into the comparator core MSB-first and returns a registered less/equal/greater result, tagged with the requester ID, through a second valid/ready handshake.

---
 rtl/serial_cmp_pkg.sv | 28 ++
 rtl/serial_compare_msb_core.sv | 42 ++++
 rtl/serial_compare_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/serial_cmp_pkg.sv
// Purpose : shared types for the serial compare arbiter and its comparator core.
// Latency : n/a (types only).
// Backpressure : n/a (types only).
// Contents: controller state enum, comparator core state enum, result flag struct.
package serial_cmp_pkg;

    // Controller states of the arbiter/shifter.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } ctrl_state_t;

    // Comparator core states; anything other than EQUAL is sticky until clr.
    typedef enum logic [1:0] {
        EQUAL   = 2'd0,
        LESS    = 2'd1,
        GREATER = 2'd2
    } core_state_t;

    // One-hot comparison outcome of A versus B.
    typedef struct packed {
        logic less;
        logic eq;
        logic greater;
    } cmp_result_t;

endpackage

// File: rtl/serial_compare_msb_core.sv
// Purpose : MSB-first bit-serial magnitude comparator (A versus B).
// Latency : outputs are combinational from the current bit pair and the stored state.
// Backpressure : none; the state only advances while bit_en is high.
// Ports   : clk, rst (sync, active-high), clr (restart at EQUAL), bit_en (bit strobe),
//           a/b (current operand bits), less/eq/greater (combinational result).
module serial_compare_msb_core
    import serial_cmp_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic bit_en,
    input  logic a,
    input  logic b,
    output logic less,
    output logic eq,
    output logic greater
);

    core_state_t state;

    // The first differing bit (seen MSB-first) decides the outcome; later bits
    // cannot change it, so only the EQUAL state ever moves.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state <= EQUAL;
        end else if (bit_en && (state == EQUAL)) begin
            if (a && !b) begin
                state <= GREATER;
            end else if (!a && b) begin
                state <= LESS;
            end
        end
    end

    // Outputs fold in the bit currently presented, so the final bit's decision
    // is visible in the same cycle it is shifted in.
    assign eq      = (state == EQUAL) & (a ~^ b);
    assign less    = (state == LESS)    | ((state == EQUAL) & ~a &  b);
    assign greater = (state == GREATER) | ((state == EQUAL) &  a & ~b);

endmodule

// File: rtl/serial_compare_arbiter.sv
// Purpose : round-robin shares one serial MSB-first comparator among N_REQ requesters.
// Latency : accept at T -> rsp_valid at T+WIDTH+1 (early exit: T+k+2 for first mismatch at MSB-offset k).
// Backpressure : result held in DONE until rsp_ready; no request is accepted until the cycle after that handshake.
// Ports   : clk, rst (sync, active-high); req_valid/req_ready (one-hot grant), req_a/req_b
//           (packed WIDTH-bit slices per requester); rsp_valid/rsp_ready, rsp_id, rsp_less/eq/greater.
// Option  : define SERIAL_CMP_EARLY_EXIT_EN to finish as soon as the first differing bit is seen.
module serial_compare_arbiter
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_REQ = 2,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   rsp_less,
    output logic                   rsp_eq,
    output logic                   rsp_greater
);

    localparam int CNT_W = $clog2(WIDTH);

    ctrl_state_t      state;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  id_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [CNT_W-1:0] cnt;
    cmp_result_t      result;

    logic             grant_found;
    logic [ID_W-1:0]  grant_idx;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             accept;
    logic             finish_shift;

    logic             core_clr;
    logic             core_bit_en;
    logic             core_less;
    logic             core_eq;
    logic             core_greater;

    // Round-robin search: the first valid requester at or after rr_ptr wins.
    // The sum is one bit wider than an ID so the wrap can be done by subtraction.
    always_comb begin
        logic [ID_W:0] probe;
        grant_found = 1'b0;
        grant_idx   = '0;
        probe       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            probe = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (probe >= (ID_W+1)'(N_REQ)) begin
                probe = probe - (ID_W+1)'(N_REQ);
            end
            if (!grant_found && req_valid[probe[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = probe[ID_W-1:0];
            end
        end
    end

    // Grant is purely a function of state and req_valid, never of rsp_ready.
    always_comb begin
        req_ready = '0;
        if ((state == IDLE) && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Operand mux with constant slice bounds per requester.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                sel_a = req_a[i*WIDTH +: WIDTH];
                sel_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign accept      = (state == IDLE) && grant_found;
    assign core_clr    = accept;
    assign core_bit_en = (state == SHIFT);

`ifdef SERIAL_CMP_EARLY_EXIT_EN
    // A decided core cannot change its mind, so stop at the first mismatch.
    assign finish_shift = (cnt == '0) || core_less || core_greater;
`else
    assign finish_shift = (cnt == '0);
`endif

    serial_compare_msb_core u_core (
        .clk     (clk),
        .rst     (rst),
        .clr     (core_clr),
        .bit_en  (core_bit_en),
        .a       (a_reg[cnt]),
        .b       (b_reg[cnt]),
        .less    (core_less),
        .eq      (core_eq),
        .greater (core_greater)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            id_reg    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            cnt       <= '0;
            result    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg  <= sel_a;
                        b_reg  <= sel_b;
                        id_reg <= grant_idx;
                        cnt    <= CNT_W'(WIDTH - 1);
                        rr_ptr <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (finish_shift) begin
                        result    <= '{less: core_less, eq: core_eq, greater: core_greater};
                        rsp_id    <= id_reg;
                        rsp_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    // Returning to IDLE here keeps the handshake cycle free of new grants.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rsp_less    = result.less;
    assign rsp_eq      = result.eq;
    assign rsp_greater = result.greater;

endmodule
